// File: rtl/bp_pkg.sv
// Shared types and counter arithmetic for the branch predictor controller.
package bp_pkg;

  typedef logic [1:0] bp_ctr_t;

  typedef enum logic {S_INIT, S_RUN} bp_state_e;

  localparam bp_ctr_t CTR_MAX = 2'b11;
  localparam bp_ctr_t CTR_MIN = 2'b00;

  function automatic bp_ctr_t bp_sat_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != CTR_MAX)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_MIN)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Small circular queue of resolved-branch updates ({index, taken}) awaiting a free table cycle.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)
        r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating branch counter table shared by fetch lookups and queued execute updates.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter bp_ctr_t     INIT_CTR = 2'b11,
  parameter int unsigned UQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic [PC_W-1:0] req_pc,
  output logic            req_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  output logic            upd_ready,
  output logic            init_busy
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned QW      = INDEX_W + 1;

  bp_state_e          r_state;
  bp_state_e          w_state_nxt;
  logic [INDEX_W-1:0] r_ptr;
  bp_ctr_t            r_table [ENTRIES];
  logic               r_pred_valid;
  logic               r_pred_taken;

  logic [INDEX_W-1:0] w_lidx;
  logic [INDEX_W-1:0] w_uidx;
  logic               w_lookup;
  logic               w_upd_acc;
  logic               w_drain;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [QW-1:0]      w_head;
  logic               w_we;
  logic [INDEX_W-1:0] w_widx;
  bp_ctr_t            w_wdata;
  logic               w_unused_pc;

  assign w_unused_pc = ^{req_pc[PC_W-1:INDEX_W+2], req_pc[1:0],
                         upd_pc[PC_W-1:INDEX_W+2], upd_pc[1:0]};

`ifdef GSHARE_EN
  logic [INDEX_W-1:0] r_ghr;

  // Update index uses the pre-shift history so it matches the lookup that predicted it.
  assign w_lidx = req_pc[INDEX_W+1:2] ^ r_ghr;
  assign w_uidx = upd_pc[INDEX_W+1:2] ^ r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ghr <= '0;
    else if (w_upd_acc)
      r_ghr <= {r_ghr[INDEX_W-2:0], upd_taken};
  end
`else
  assign w_lidx = req_pc[INDEX_W+1:2];
  assign w_uidx = upd_pc[INDEX_W+1:2];
`endif

  assign w_lookup  = req_valid && req_ready;
  assign w_upd_acc = upd_valid && upd_ready;

  bp_update_fifo #(
    .DEPTH (UQ_DEPTH),
    .W     (QW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_upd_acc),
    .i_data  ({w_uidx, upd_taken}),
    .i_pop   (w_drain),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    init_busy   = 1'b0;
    req_ready   = 1'b0;
    upd_ready   = 1'b0;
    w_drain     = 1'b0;
    w_we        = 1'b0;
    w_widx      = r_ptr;
    w_wdata     = INIT_CTR;
    case (r_state)
      S_INIT: begin
        init_busy = 1'b1;
        w_we      = 1'b1;
        if (r_ptr == INDEX_W'(ENTRIES - 1))
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        req_ready = 1'b1;
        upd_ready = !w_fifo_full;
        // Lookup owns the single table port; the queue drains only on otherwise idle cycles.
        w_drain   = !req_valid && !w_fifo_empty;
        w_we      = w_drain;
        w_widx    = w_head[QW-1:1];
        w_wdata   = bp_sat_next(r_table[w_head[QW-1:1]], w_head[0]);
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT)
        r_ptr <= r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      r_table[w_widx] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= w_lookup;
      if (w_lookup)
        r_pred_taken <= r_table[w_lidx][1];
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench for branch_predict_ctrl: expected predictions are queued at drive time
// and compared when pred_valid appears.
module tb_branch_predict_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        init_busy;

  int unsigned n_checks;
  int unsigned n_fail;
  int unsigned n_upd_acc;

  bit          sb [$];
  bit [1:0]    mdl [64];
  bit [1:0]    mdl_snap [64];
  bit [5:0]    ghr;
  bit          mon_en;
  bit          mon_acc;
  bit          mon_exp;

  branch_predict_ctrl #(
    .PC_W     (32),
    .INDEX_W  (6),
    .INIT_CTR (2'b11),
    .UQ_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_pc     (req_pc),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .init_busy  (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] sat(input bit [1:0] c, input bit t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic bit [5:0] idx_of(input logic [31:0] pc);
    bit [5:0] i;
    i = pc[7:2];
`ifdef GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mdl[i] = 2'b11;
    ghr = '0;
    sb.delete();
  endtask

  // Drives one cycle from a negedge; model updates at acceptance, lookups read the model first.
  task automatic cyc(input bit rv, input logic [31:0] rpc, input bit uv,
                     input logic [31:0] upc, input bit ut);
    bit [5:0] ui;
    req_valid = rv; req_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut;
    #1;
    if (rv && req_ready) sb.push_back(mdl[idx_of(rpc)][1]);
    if (uv && upd_ready) begin
      n_upd_acc++;
      ui = idx_of(upc);
      mdl[ui] = sat(mdl[ui], ut);
      ghr = {ghr[4:0], ut};
    end
    @(negedge clk);
    req_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic lookup_snap(input logic [31:0] pc);
    req_valid = 1'b1; req_pc = pc;
    #1;
    if (req_ready) sb.push_back(mdl_snap[idx_of(pc)][1]);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, '0, 0, '0, 0);
  endtask

  task automatic wait_init();
    int unsigned cnt;
    cnt = 0;
    while (init_busy === 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_eq("init_len", cnt, 64);
    check_eq("req_ready_after_init", req_ready, 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_init_busy"}, init_busy, 1);
    check_eq({tag, "_req_ready"}, req_ready, 0);
    check_eq({tag, "_upd_ready"}, upd_ready, 0);
    check_eq({tag, "_pred_valid"}, pred_valid, 0);
    check_eq({tag, "_pred_taken"}, pred_taken, 0);
  endtask

  always @(posedge clk) begin
    mon_acc = req_valid && req_ready;
    if (mon_en) begin
      #1;
      check_eq("pred_valid", pred_valid, mon_acc);
      if (mon_acc) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", sb.size(), 1);
        end else begin
          mon_exp = sb.pop_front();
          check_eq("pred_taken", pred_taken, mon_exp);
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; n_upd_acc = 0; mon_en = 0;
    rst_n = 1'b0;
    req_valid = 0; req_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_init();
    mon_en = 1;

    // Fresh entry predicts taken; an idle cycle gives no prediction.
    cyc(1, 32'h100, 0, '0, 0);
    idle(2);

    // 11 -> 10 -> 01 on index 0.
    cyc(0, '0, 1, 32'h100, 0);
    cyc(0, '0, 1, 32'h100, 0);
    idle(3);
    cyc(1, 32'h100, 0, '0, 0);
    idle(1);

    // Queued same-index update is not visible to the lookup that wins the port.
    mdl_snap = mdl;
    cyc(0, '0, 1, 32'h100, 1);
    lookup_snap(32'h100);
    idle(3);
    cyc(1, 32'h100, 0, '0, 0);
    idle(1);

    // Saturation at 00 and 11 on index 1.
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 32'h104, 0);
    cyc(0, '0, 1, 32'h104, 1);
    idle(3);
    cyc(1, 32'h104, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 32'h104, 1);
    idle(3);
    cyc(1, 32'h104, 0, '0, 0);
    idle(1);

    // Continuous lookups starve the drain until the queue is full.
    n_upd_acc = 0;
    for (int i = 0; i < 3; i++) cyc(1, 32'h10C, 1, 32'h110, 0);
    check_eq("starve_accepted", n_upd_acc, 2);
    check_eq("starve_upd_ready", upd_ready, 0);
    idle(1);
    check_eq("drain_upd_ready", upd_ready, 1);
    idle(3);
    cyc(1, 32'h110, 0, '0, 0);
    idle(2);
    check_eq("sb_empty_mid", sb.size(), 0);

    // Reset in the middle of the sweep.
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_eq("midsweep_busy", init_busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_init();
    mon_en = 1;

    // Reset with two queued updates; they must be discarded.
    cyc(1, 32'h10C, 1, 32'h114, 0);
    cyc(1, 32'h10C, 1, 32'h114, 0);
    check_eq("queued_full", upd_ready, 0);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_q");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_init();
    mon_en = 1;
    idle(3);
    cyc(1, 32'h114, 0, '0, 0);
    idle(2);
    check_eq("sb_empty_end", sb.size(), 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
